// File: rtl/i2c_pkg.sv
// Shared types and constants for the AT24C02-style I2C EEPROM target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV,
    DEV_ACK,
    WADDR,
    WADDR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK
  } i2c_state_e;

  localparam logic       RW_WRITE         = 1'b0;
  localparam logic       RW_READ          = 1'b1;
  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'b101_0000;

  // Increment only the in-page bits; the page number is held.
  function automatic logic [7:0] page_inc(input logic [7:0] ptr, input int unsigned page_bits);
    logic [7:0] mask;
    mask = 8'((32'd1 << page_bits) - 32'd1);
    return (ptr & ~mask) | ((ptr + 8'd1) & mask);
  endfunction

endpackage

// File: rtl/i2c_eeprom_target_if.sv
// Local observation port of the EEPROM target: debug read port, write strobe, busy flag.
interface i2c_eeprom_target_if;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       wr_pulse;
  logic [7:0] wr_addr;
  logic       busy;

  modport slave  (input dbg_addr, output dbg_data, output wr_pulse, output wr_addr, output busy);
  modport master (output dbg_addr, input dbg_data, input wr_pulse, input wr_addr, input busy);
endinterface

// File: rtl/i2c_bus_sync.sv
// scl/sda front end: 2-FF synchronizers, FILT_LEN-sample glitch filter, edge/START/STOP strobes.
module i2c_bus_sync #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic sclk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic [1:0]          scl_sync_q, sda_sync_q;
  logic [FILT_LEN-2:0] scl_hist_q, sda_hist_q;
  logic [FILT_LEN-1:0] scl_win, sda_win;
  logic                scl_f_q, sda_f_q, scl_prev_q, sda_prev_q;

  assign scl_win = {scl_hist_q, scl_sync_q[1]};
  assign sda_win = {sda_hist_q, sda_sync_q[1]};

  always_ff @(posedge sclk) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_win[FILT_LEN-2:0];
      sda_hist_q <= sda_win[FILT_LEN-2:0];
      if (&scl_win) scl_f_q <= 1'b1;
      else if (~|scl_win) scl_f_q <= 1'b0;
      if (&sda_win) sda_f_q <= 1'b1;
      else if (~|sda_win) sda_f_q <= 1'b0;
      scl_prev_q <= scl_f_q;
      sda_prev_q <= sda_f_q;
    end
  end

  // START/STOP need scl high on both samples so an sda edge at an scl fall stays data.
  assign scl_rise_o = scl_f_q & ~scl_prev_q;
  assign scl_fall_o = ~scl_f_q & scl_prev_q;
  assign start_o    = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
  assign stop_o     = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;
  assign sda_o      = sda_f_q;

endmodule

// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a 256x8 AT24C02-style EEPROM on open-drain scl/sda.
// Define I2C_TGT_WRITE_PROTECT_EN to add the wp input that NACKs and drops data bytes.
module i2c_eeprom_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR  = DEV_ADDR_DEFAULT,
  parameter int unsigned PAGE_BITS = 3,
  parameter int unsigned FILT_LEN  = 3
) (
  input  logic sclk,
  input  logic rst,
  input  logic scl,
  inout  wire  sda,
`ifdef I2C_TGT_WRITE_PROTECT_EN
  input  logic wp,
`endif
  i2c_eeprom_target_if.slave dbg
);

  logic       scl_rise, scl_fall, start_det, stop_det, sda_f;
  i2c_state_e state_q;
  logic [7:0] mem_q [256];
  logic [7:0] shreg_q, ptr_q, wr_addr_q, dbg_data_q;
  logic [2:0] bit_cnt_q;
  logic       ph_q, sda_oe_q, busy_q, wr_pulse_q;
  logic [7:0] byte_d;
  logic       wp_active, commit_d;

  i2c_bus_sync #(.FILT_LEN(FILT_LEN)) u_sync (
    .sclk      (sclk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det),
    .sda_o     (sda_f)
  );

`ifdef I2C_TGT_WRITE_PROTECT_EN
  assign wp_active = wp;
`else
  assign wp_active = 1'b0;
`endif

  assign byte_d   = {shreg_q[6:0], sda_f};
  assign commit_d = (state_q == WDATA) && scl_rise && (bit_cnt_q == 3'd7) && !wp_active;

  always_ff @(posedge sclk) begin
    if (commit_d) mem_q[ptr_q] <= byte_d;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      ptr_q      <= '0;
      wr_addr_q  <= '0;
      dbg_data_q <= '0;
      bit_cnt_q  <= '0;
      ph_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
    end else begin
      dbg_data_q <= mem_q[dbg.dbg_addr];
      wr_pulse_q <= 1'b0;
      if (stop_det) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
        ph_q     <= 1'b0;
      end else if (start_det) begin
        state_q   <= DEV;
        sda_oe_q  <= 1'b0;
        bit_cnt_q <= '0;
        ph_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: busy_q <= 1'b0;
          DEV, WADDR: if (scl_rise) begin
            shreg_q   <= byte_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= (state_q == DEV) ? DEV_ACK : WADDR_ACK;
          end
          WDATA: if (scl_rise) begin
            shreg_q   <= byte_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (wp_active) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q    <= WDATA_ACK;
                wr_pulse_q <= 1'b1;
                wr_addr_q  <= ptr_q;
                ptr_q      <= page_inc(ptr_q, PAGE_BITS);
              end
            end
          end
          // ph_q=0: first fall after the byte drives the ACK; ph_q=1: ACK clock ends.
          DEV_ACK: if (scl_fall) begin
            if (!ph_q) begin
              if (shreg_q[7:1] == DEV_ADDR) begin
                sda_oe_q <= 1'b1;
                ph_q     <= 1'b1;
                busy_q   <= 1'b1;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              ph_q      <= 1'b0;
              bit_cnt_q <= '0;
              if (shreg_q[0] == RW_READ) begin
                state_q  <= RDATA;
                shreg_q  <= mem_q[ptr_q];
                sda_oe_q <= ~mem_q[ptr_q][7];
              end else begin
                state_q  <= WADDR;
                sda_oe_q <= 1'b0;
              end
            end
          end
          WADDR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!ph_q) begin
              sda_oe_q <= 1'b1;
              ph_q     <= 1'b1;
              if (state_q == WADDR_ACK) ptr_q <= shreg_q;
            end else begin
              sda_oe_q  <= 1'b0;
              ph_q      <= 1'b0;
              bit_cnt_q <= '0;
              state_q   <= WDATA;
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= RACK;
                ph_q    <= 1'b0;
              end
            end else if (scl_fall) begin
              shreg_q  <= {shreg_q[6:0], 1'b0};
              sda_oe_q <= ~shreg_q[6];
            end
          end
          RACK: begin
            if (scl_fall) begin
              if (!ph_q) begin
                sda_oe_q <= 1'b0;
              end else begin
                state_q   <= RDATA;
                ph_q      <= 1'b0;
                bit_cnt_q <= '0;
                shreg_q   <= mem_q[ptr_q];
                sda_oe_q  <= ~mem_q[ptr_q][7];
              end
            end else if (scl_rise) begin
              if (sda_f) begin
                state_q  <= IDLE;
                busy_q   <= 1'b0;
                sda_oe_q <= 1'b0;
              end else begin
                ph_q  <= 1'b1;
                ptr_q <= ptr_q + 8'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sda          = sda_oe_q ? 1'b0 : 1'bz;
  assign dbg.dbg_data = dbg_data_q;
  assign dbg.wr_pulse = wr_pulse_q;
  assign dbg.wr_addr  = wr_addr_q;
  assign dbg.busy     = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Directed bench for i2c_eeprom_target: table of byte writes plus hand-written read/wrap/reset sequences.
module tb_i2c_eeprom_target;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  logic scl  = 1'b1;
  logic m_oe = 1'b0;
  wire  sda;
  int   q    = 620;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

`ifdef I2C_TGT_WRITE_PROTECT_EN
  logic wp = 1'b0;
`endif

  i2c_eeprom_target_if dbg_if ();

  i2c_eeprom_target dut (
    .sclk(sclk),
    .rst (rst),
    .scl (scl),
    .sda (sda),
`ifdef I2C_TGT_WRITE_PROTECT_EN
    .wp  (wp),
`endif
    .dbg (dbg_if.slave)
  );

  always #10 sclk = ~sclk;

  int pulse_cnt = 0;
  always @(posedge sclk) if (dbg_if.wr_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;

  int tests = 0;
  int fails = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic bus_start();
    m_oe = 1'b0; #(q);
    scl  = 1'b1; #(q);
    m_oe = 1'b1; #(q);
    scl  = 1'b0; #(q);
  endtask

  task automatic bus_stop();
    m_oe = 1'b1; #(q);
    scl  = 1'b1; #(q);
    m_oe = 1'b0; #(q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_oe = ~b[i]; #(q);
      scl  = 1'b1;  #(2*q);
      scl  = 1'b0;  #(q);
    end
    m_oe = 1'b0; #(q);
    scl  = 1'b1; #(q);
    ack  = (sda === 1'b0); #(q);
    scl  = 1'b0; #(q);
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] b);
    m_oe = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #(q); scl = 1'b1;
      #(q); b[i] = sda;
      #(q); scl = 1'b0;
    end
    #(q); m_oe = send_ack;
    #(q); scl  = 1'b1;
    #(2*q); scl = 1'b0;
    #(q); m_oe = 1'b0;
  endtask

  task automatic set_ptr_restart(input logic [7:0] a, output logic ok);
    logic a0, a1, a2;
    bus_start();
    write_byte(8'hA0, a0);
    write_byte(a, a1);
    bus_start();
    write_byte(8'hA1, a2);
    ok = a0 & a1 & a2;
  endtask

  task automatic dbg_rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge sclk);
    dbg_if.dbg_addr = a;
    @(posedge sclk);
    @(negedge sclk);
    d = dbg_if.dbg_data;
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       exp_ack;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [7];

  logic       ack, ok;
  logic [7:0] d, d0, d1;
  int         p0;

  initial begin
    vecs[0] = '{8'hA0, 8'h20, 8'h69, 1'b1, 8'h69};
    vecs[1] = '{8'hA0, 8'h05, 8'h3C, 1'b1, 8'h3C};
    vecs[2] = '{8'hA0, 8'hFF, 8'h81, 1'b1, 8'h81};
    vecs[3] = '{8'hA0, 8'h00, 8'h5A, 1'b1, 8'h5A};
    vecs[4] = '{8'hA0, 8'h10, 8'h11, 1'b1, 8'h11};
    vecs[5] = '{8'hA0, 8'h08, 8'h88, 1'b1, 8'h88};
    vecs[6] = '{8'hA2, 8'h10, 8'hEE, 1'b0, 8'h11};

    dbg_if.dbg_addr = 8'h00;
    repeat (4) @(negedge sclk);
    check1("rst_sda", sda, 1'b1);
    check1("rst_busy", dbg_if.busy, 1'b0);
    check1("rst_wr_pulse", dbg_if.wr_pulse, 1'b0);
    check8("rst_wr_addr", dbg_if.wr_addr, 8'h00);
    check8("rst_dbg_data", dbg_if.dbg_data, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge sclk);

    for (int i = 0; i < 7; i++) begin
      p0 = pulse_cnt;
      bus_start();
      write_byte(vecs[i].dev, ack);
      check1($sformatf("dev_ack[%0d]", i), ack, vecs[i].exp_ack);
      check1($sformatf("busy_after_dev[%0d]", i), dbg_if.busy, vecs[i].exp_ack);
      if (vecs[i].exp_ack) begin
        write_byte(vecs[i].waddr, ack);
        check1($sformatf("waddr_ack[%0d]", i), ack, 1'b1);
        write_byte(vecs[i].wdata, ack);
        check1($sformatf("wdata_ack[%0d]", i), ack, 1'b1);
        check8($sformatf("wr_addr[%0d]", i), dbg_if.wr_addr, vecs[i].waddr);
      end
      bus_stop();
      check1($sformatf("busy_after_stop[%0d]", i), dbg_if.busy, 1'b0);
      check8($sformatf("wr_pulses[%0d]", i), 8'(pulse_cnt - p0), vecs[i].exp_ack ? 8'd1 : 8'd0);
      dbg_rd(vecs[i].waddr, d);
      check8($sformatf("dbg_data[%0d]", i), d, vecs[i].exp_rd);
    end

    // Random read of word 0x20 at 400 kHz.
    set_ptr_restart(8'h20, ok);
    check1("rr_acks", ok, 1'b1);
    read_byte(1'b0, d);
    check8("rr_data", d, 8'h69);
    check1("rr_nack_release", sda, 1'b1);
    check1("rr_busy_after_nack", dbg_if.busy, 1'b0);
    bus_stop();
    check1("rr_busy_after_stop", dbg_if.busy, 1'b0);

    q = 240;

    // Page write wrapping 0x06 -> 0x07 -> 0x00.
    p0 = pulse_cnt;
    bus_start();
    write_byte(8'hA0, ok);
    write_byte(8'h06, ack); ok = ok & ack;
    write_byte(8'hAA, ack); ok = ok & ack;
    write_byte(8'hBB, ack); ok = ok & ack;
    write_byte(8'hCC, ack); ok = ok & ack;
    check8("pw_last_wr_addr", dbg_if.wr_addr, 8'h00);
    bus_stop();
    check1("pw_acks", ok, 1'b1);
    check8("pw_pulses", 8'(pulse_cnt - p0), 8'd3);
    dbg_rd(8'h06, d); check8("pw_mem06", d, 8'hAA);
    dbg_rd(8'h07, d); check8("pw_mem07", d, 8'hBB);
    dbg_rd(8'h00, d); check8("pw_mem00", d, 8'hCC);
    dbg_rd(8'h08, d); check8("pw_mem08", d, 8'h88);

    // Sequential read wrapping 0xFF -> 0x00.
    set_ptr_restart(8'hFF, ok);
    check1("sr_acks", ok, 1'b1);
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    bus_stop();
    check8("sr_byte0", d0, 8'h81);
    check8("sr_byte1", d1, 8'hCC);

    // Reset while the target pulls sda low for bit 7 of 0x69.
    set_ptr_restart(8'h20, ok);
    check1("rm_acks", ok, 1'b1);
    check1("rm_target_drives", sda, 1'b0);
    @(negedge sclk);
    rst = 1'b1;
    @(negedge sclk);
    check1("rm_sda_released", sda, 1'b1);
    check1("rm_busy", dbg_if.busy, 1'b0);
    rst = 1'b0;
    bus_stop();

    // Pointer was reset to 0x00, so a current-address read returns mem[0x00].
    bus_start();
    write_byte(8'hA1, ack);
    check1("ca_ack", ack, 1'b1);
    check1("ca_busy", dbg_if.busy, 1'b1);
    read_byte(1'b0, d);
    bus_stop();
    check8("ca_data", d, 8'hCC);
    check1("ca_busy_after_stop", dbg_if.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
